// File: rtl/key_cmd_pkg.sv
// key_cmd_pkg: shared key codes, states and move encodings
// for the keyboard command stage.
package key_cmd_pkg;

  localparam logic [8:0] KEY_A         = 9'h01C;
  localparam logic [8:0] KEY_D         = 9'h023;
  localparam logic [8:0] KEY_SPACE     = 9'h029;
  localparam logic [8:0] KEY_ENTER     = 9'h05A;
  localparam logic [8:0] KEY_ENTER_EXT = 9'h15A;

  typedef enum logic [1:0] {
    COVER,
    PLAY,
    DEAD_LOCK
  } state_t;

  localparam logic [1:0] MOVE_NONE  = 2'b00;
  localparam logic [1:0] MOVE_LEFT  = 2'b10;
  localparam logic [1:0] MOVE_RIGHT = 2'b01;

endpackage

// File: rtl/cmd_timer.sv
// cmd_timer: loadable down-counter that saturates at zero.
// The zero flag reports when the count has run out.
module cmd_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  // load takes priority over the free-running decrement
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/key_cmd.sv
// key_cmd: keyboard command stage with COVER/PLAY game FSM,
// held move level, debounced jump and start pulses.
module key_cmd
  import key_cmd_pkg::*;
#(
  parameter int LOCKOUT_CYCLES = 50_000_000,
  parameter int JUMP_COOLDOWN  = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [8:0] key_code,
  input  logic       key_make,
  input  logic       slime_die,
  output logic       game_state,
  output logic       start_pulse,
  output logic [1:0] move,
  output logic       jump_pulse
);

  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int JW = $clog2(JUMP_COOLDOWN + 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [JW-1:0] COOL_LOAD = JW'(JUMP_COOLDOWN - 1);

  state_t state, state_n;
  logic a_held, a_n;
  logic d_held, d_n;
  logic space_held, sp_n;
  logic last_right, last_n;
  logic start_n, jump_n, game_n;
  logic [1:0] move_n;
  logic lock_load, lock_zero;
  logic cool_load, cool_zero;
  logic [JW-1:0] cool_val;
  logic is_enter;

  cmd_timer #(.W(LW)) u_lock (
    .clk   (clk),
    .rst   (rst),
    .load  (lock_load),
    .value (LOCK_LOAD),
    .zero  (lock_zero)
  );

  cmd_timer #(.W(JW)) u_cool (
    .clk   (clk),
    .rst   (rst),
    .load  (cool_load),
    .value (cool_val),
    .zero  (cool_zero)
  );

  // next state, held-key tracking and next registered outputs
  always_comb begin
    state_n   = state;
    a_n       = a_held;
    d_n       = d_held;
    sp_n      = space_held;
    last_n    = last_right;
    start_n   = 1'b0;
    jump_n    = 1'b0;
    lock_load = 1'b0;
    cool_load = 1'b0;
    cool_val  = '0;
    is_enter  = (key_code == KEY_ENTER) ||
                (key_code == KEY_ENTER_EXT);
    case (state)
      COVER: begin
        if (key_valid && key_make && is_enter) begin
          state_n = PLAY;
          start_n = 1'b1;
        end
      end
      PLAY: begin
        if (slime_die) begin
          state_n   = DEAD_LOCK;
          lock_load = 1'b1;
          a_n       = 1'b0;
          d_n       = 1'b0;
          sp_n      = 1'b0;
        end else if (key_valid) begin
          case (key_code)
            KEY_A: begin
              a_n = key_make;
              if (key_make) last_n = 1'b0;
            end
            KEY_D: begin
              d_n = key_make;
              if (key_make) last_n = 1'b1;
            end
            KEY_SPACE: begin
              if (key_make && !space_held && cool_zero) begin
                jump_n    = 1'b1;
                cool_load = 1'b1;
                cool_val  = COOL_LOAD;
              end
              sp_n = key_make;
            end
            default: ;
          endcase
        end
      end
      DEAD_LOCK: begin
        if (lock_zero) begin
          state_n   = COVER;
          a_n       = 1'b0;
          d_n       = 1'b0;
          sp_n      = 1'b0;
          cool_load = 1'b1;
        end
      end
      default: state_n = COVER;
    endcase
    game_n = (state_n == PLAY);
    move_n = MOVE_NONE;
    if (game_n) begin
      if (a_n && d_n) begin
        move_n = last_n ? MOVE_RIGHT : MOVE_LEFT;
      end else if (a_n) begin
        move_n = MOVE_LEFT;
      end else if (d_n) begin
        move_n = MOVE_RIGHT;
      end
    end
  end

  // state, held bits and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COVER;
      a_held      <= 1'b0;
      d_held      <= 1'b0;
      space_held  <= 1'b0;
      last_right  <= 1'b0;
      game_state  <= 1'b0;
      start_pulse <= 1'b0;
      move        <= MOVE_NONE;
      jump_pulse  <= 1'b0;
    end else begin
      state       <= state_n;
      a_held      <= a_n;
      d_held      <= d_n;
      space_held  <= sp_n;
      last_right  <= last_n;
      game_state  <= game_n;
      start_pulse <= start_n;
      move        <= move_n;
      jump_pulse  <= jump_n;
    end
  end

endmodule

// File: tb/tb_key_cmd.sv
// tb_key_cmd: directed and random stimulus against a
// cycle-stamp behavioural model of the command stage.
module tb_key_cmd;

  localparam int L = 20;
  localparam int J = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [8:0] key_code;
  logic       key_make;
  logic       slime_die;
  logic       game_state;
  logic       start_pulse;
  logic [1:0] move;
  logic       jump_pulse;

  key_cmd #(
    .LOCKOUT_CYCLES (L),
    .JUMP_COOLDOWN  (J)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_make    (key_make),
    .slime_die   (slime_die),
    .game_state  (game_state),
    .start_pulse (start_pulse),
    .move        (move),
    .jump_pulse  (jump_pulse)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // model: 0 cover, 1 play, 2 dead; timing kept as cycle stamps
  int m_mode = 0;
  int m_dead_end = 0;
  int m_jump_ok = 0;
  bit m_a, m_d, m_sp, m_last_d;
  logic [4:0] exp_v;

  function automatic logic [4:0] outs();
    return {game_state, start_pulse, move, jump_pulse};
  endfunction

  task automatic chk(input string nm,
                     input logic [4:0] act,
                     input logic [4:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, want);
    end
  endtask

  task automatic model(input bit r, input bit kv,
                       input logic [8:0] c,
                       input bit mk, input bit die);
    bit st, jp;
    logic [1:0] mv;
    st = 1'b0;
    jp = 1'b0;
    if (r) begin
      m_mode = 0;
      m_a = 0; m_d = 0; m_sp = 0; m_last_d = 0;
      m_jump_ok = 0;
    end else begin
      case (m_mode)
        0: begin
          if (kv && mk && (c == 9'h05A || c == 9'h15A)) begin
            m_mode = 1;
            st = 1'b1;
          end
        end
        1: begin
          if (die) begin
            m_mode = 2;
            m_dead_end = cyc + 1 + L;
            m_a = 0; m_d = 0; m_sp = 0;
          end else if (kv) begin
            if (c == 9'h01C) begin
              m_a = mk;
              if (mk) m_last_d = 0;
            end else if (c == 9'h023) begin
              m_d = mk;
              if (mk) m_last_d = 1;
            end else if (c == 9'h029) begin
              if (mk && !m_sp && cyc >= m_jump_ok) begin
                jp = 1'b1;
                m_jump_ok = cyc + J;
              end
              m_sp = mk;
            end
          end
        end
        default: begin
          if (cyc + 1 >= m_dead_end) begin
            m_mode = 0;
            m_a = 0; m_d = 0; m_sp = 0;
            m_jump_ok = 0;
          end
        end
      endcase
    end
    if (m_mode != 1) mv = 2'b00;
    else if (m_a && m_d) mv = m_last_d ? 2'b01 : 2'b10;
    else mv = {m_a, m_d};
    exp_v = {(m_mode == 1), st, mv, jp};
  endtask

  task automatic step(input bit r, input bit kv,
                      input logic [8:0] c,
                      input bit mk, input bit die);
    rst       = r;
    key_valid = kv;
    key_code  = c;
    key_make  = mk;
    slime_die = die;
    model(r, kv, c, mk, die);
    @(posedge clk);
    #1;
    chk("model", outs(), exp_v);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 9'h000, 0, 0);
  endtask

  task automatic key(input logic [8:0] c, input bit mk);
    step(0, 1, c, mk, 0);
  endtask

  logic [8:0] codes [6];
  int t0;

  initial begin
    codes[0] = 9'h01C; codes[1] = 9'h023; codes[2] = 9'h029;
    codes[3] = 9'h05A; codes[4] = 9'h15A; codes[5] = 9'h01B;

    step(1, 0, 9'h000, 0, 0);
    step(1, 0, 9'h000, 0, 0);
    chk("reset", outs(), 5'b00000);

    key(9'h01B, 1);
    key(9'h029, 1);
    key(9'h01B, 0);
    chk("cover_ignore", outs(), 5'b00000);

    key(9'h05A, 1);
    chk("enter", outs(), 5'b11000);
    idle(1);
    chk("start_width", outs(), 5'b10000);

    key(9'h01C, 1); chk("a_make", outs(), 5'b10100);
    key(9'h023, 1); chk("d_make", outs(), 5'b10010);
    key(9'h023, 0); chk("d_brk", outs(), 5'b10100);
    key(9'h01B, 1); chk("unk_play", outs(), 5'b10100);
    key(9'h05A, 1); chk("enter_play", outs(), 5'b10100);
    key(9'h01C, 0); chk("a_brk", outs(), 5'b10000);
    key(9'h01C, 0); chk("brk_unheld", outs(), 5'b10000);

    t0 = cyc;
    key(9'h029, 1); chk("jump1", outs(), 5'b10001);
    for (int i = 0; i < 3; i++) begin
      key(9'h029, 1);
      chk("typematic", outs(), 5'b10000);
    end
    key(9'h029, 0);
    while (cyc < t0 + 12) idle(1);
    key(9'h029, 1); chk("jump2", outs(), 5'b10001);
    key(9'h029, 0);
    idle(3);
    key(9'h029, 1); chk("cooldown", outs(), 5'b10000);
    key(9'h029, 0);

    key(9'h01C, 1);
    step(0, 1, 9'h029, 1, 1);
    chk("die", outs(), 5'b00000);
    for (int i = 0; i < L; i++) begin
      key(9'h05A, 1);
      chk("lockout", outs(), 5'b00000);
    end
    key(9'h15A, 1);
    chk("enter_ext", outs(), 5'b11000);

    key(9'h01C, 1);
    chk("a_again", outs(), 5'b10100);
    step(1, 1, 9'h023, 1, 0);
    chk("rst_mid", outs(), 5'b00000);
    key(9'h023, 1);
    chk("rst_cover", outs(), 5'b00000);

    key(9'h05A, 1);
    step(0, 0, 9'h000, 0, 1);
    key(9'h01B, 1);
    chk("unk_dead", outs(), 5'b00000);
    idle(L + 2);

    for (int i = 0; i < 4000; i++) begin
      bit r, kv, mk, die;
      logic [8:0] c;
      r  = ($urandom_range(999) < 3);
      kv = ($urandom_range(1) == 1);
      mk = ($urandom_range(9) < 7);
      die = ($urandom_range(99) < 2);
      if ($urandom_range(9) == 0) c = 9'($urandom);
      else c = codes[$urandom_range(5)];
      step(r, kv, c, mk, die);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_cmd.md
# key_cmd

Keyboard command stage between the PS/2 `KeyboardDecoder` and the game logic. It converts raw make/break events into:
- a held left/right move level;
- a debounced jump pulse;
- a start pulse.

It also owns the COVER/PLAY game-state machine, including a post-death lockout that stops a held Enter key from restarting the game immediately. All outputs are registered and drive `slime_move`, the VGA mux and `Audio`.

## Interface

Parameters:
- LOCKOUT_CYCLES, 50_000_000 — clk cycles spent in DEAD_LOCK after `slime_die` (0.5 s at 100 MHz).
- JUMP_COOLDOWN, 1_000_000 — clk cycles after a `jump_pulse` during which further jumps are refused.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, synchronous, active-high.
- key_valid  in  1  one-cycle strobe from the keyboard decoder: a new event is on key_code/key_make.
- key_code  in  9  scan code; bit 8 = extended (E0) prefix.
- key_make  in  1  1 = make (press, including typematic repeats), 0 = break; qualified by key_valid.
- slime_die  in  1  level or pulse from slime_move: player died.
- game_state  out  1  0 = COVER screen, 1 = game running (PLAY).
- start_pulse  out  1  one-cycle pulse when leaving COVER.
- move  out  2  10 = left, 01 = right, 00 = none.
- jump_pulse  out  1  one-cycle jump request.

## Operation

Key codes:
- A = 0x01C.
- D = 0x023.
- Space = 0x029.
- Enter = 0x05A or 0x15A.
- All other codes are ignored; they change no state.

FSM states:
- COVER:
  - A make event with Enter → PLAY, start_pulse=1.
  - Held bits and cooldown are cleared on entry.
- PLAY:
  - slime_die=1 → DEAD_LOCK. The lockout counter loads LOCKOUT_CYCLES−1 and all held bits clear.
- DEAD_LOCK:
  - All key events are ignored.
  - The counter decrements each cycle; at 0 → COVER.
- game_state = 1 only in PLAY.

Move tracking, PLAY only:
- Held bits a_held and d_held: set on make, cleared on break.
- last_dir records which of A or D had the most recent make event.
- move = both held → last_dir; A only → 10; D only → 01; neither → 00.
- In COVER and DEAD_LOCK, move = 00.

Jump, PLAY only:
- space_held is set on Space make and cleared on Space break.
- A Space make with space_held=0 and cooldown=0 produces jump_pulse=1 and loads cooldown with JUMP_COOLDOWN−1.
- Typematic Space makes while space_held=1 produce no pulse.
- A Space make during cooldown sets space_held but produces no pulse. It is not queued.

Boundary rules:
- slime_die and a key event in the same cycle: the die transition wins; no jump_pulse and no move update.
- A break for a key that is not held has no effect.
- Enter in PLAY and Space/A/D in COVER are ignored.
- Counters saturate at 0. Widths are $clog2(param+1).

## Timing

- Reset values: game_state=0, start_pulse=0, move=00, jump_pulse=0, state=COVER, all held bits and counters 0.
- Latency: key_valid in cycle N → move / jump_pulse / start_pulse / game_state updated in N+1.
- Pulses are exactly one cycle wide.
- slime_die in cycle N → game_state=0 and move=00 in N+1. game_state stays 0 (no PLAY) until Enter arrives after the lockout.
- DEAD_LOCK lasts exactly LOCKOUT_CYCLES cycles; state is COVER in cycle N+1+LOCKOUT_CYCLES.
- A second jump is accepted no earlier than JUMP_COOLDOWN cycles after the previous pulse.
- rst mid-operation returns everything to reset values in the next cycle and overrides any same-cycle key_valid.

## Structure

- Package key_cmd_pkg holds:
  - the key code constants KEY_A, KEY_D, KEY_SPACE, KEY_ENTER, KEY_ENTER_EXT;
  - the state enum {COVER, PLAY, DEAD_LOCK};
  - the move encodings MOVE_NONE, MOVE_LEFT, MOVE_RIGHT.
- Sub-module cmd_timer: a loadable down-counter with a zero flag, parameterised by width. It is instantiated twice: lockout and jump cooldown.

## Test plan

Benches use LOCKOUT_CYCLES=20 and JUMP_COOLDOWN=10.

1. Reset, then Enter make (0x05A) → start_pulse=1 for one cycle, game_state=1 the next cycle; 0x15A behaves identically.
2. In PLAY: A make, D make, D break, A break → move 10, 01, 10, 00, each one cycle after its event.
3. Space make, three typematic Space makes, Space break, Space make 12 cycles after the first pulse → exactly two jump_pulses. A repeat at 5 cycles after break and re-press → no pulse (cooldown).
4. slime_die coincident with a Space make → no jump_pulse, game_state=0 and move=00 next cycle. Enter during the next 20 cycles is ignored; Enter after 20 cycles → start_pulse.
5. A held, then rst asserted alongside a D make → all outputs at reset values next cycle, state COVER.
6. Unknown code 0x01B make/break in all states → no output changes.
